shift_xfer_ctrl: RTL

Sequencing controller for the parallel-load, bidirectional shift register datapath. It accepts a word and a bit length over a valid/ready request port and parallel-loads the register. It then issues paced shift enables in the requested bit order, capturing the serial input line into the vacated bits, and returns the captured register contents on a valid/ready response port. It sits between a transaction source (for example a CSR or SPI-style master front end) and the shift register instance, and it owns every control input of that instance.

---
 rtl/shift_xfer_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_xfer_ctrl.sv
// rtl/shift_xfer_ctrl.sv - sequencing controller for a parallel-load bidirectional shift register
module shift_xfer_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_lsb_first,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             abort,
    output logic             busy,
    output logic             sr_load_en,
    output logic             sr_shift_en,
    output logic             sr_direction,
    output logic [WIDTH-1:0] sr_parallel_in,
    input  logic [WIDTH-1:0] sr_parallel_out
);

    localparam int PACE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT, DONE} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   bit_cnt, bit_cnt_n;
    logic [PACE_W-1:0]  pace, pace_n;
    logic               shift_n;
    logic               accept;
    logic [LEN_W-1:0]   eff_len;

    logic               req_ready_n, busy_n, load_n, rsp_valid_n, dir_n;
    logic [WIDTH-1:0]   pin_n, rsp_data_n;

    // Out-of-range lengths fall back to a full-width transfer.
    always_comb begin
        eff_len = req_len;
        if (req_len == '0 || req_len > LEN_W'(WIDTH))
            eff_len = LEN_W'(WIDTH);
    end

    assign accept = (state == IDLE) && req_valid && req_ready && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            pace           <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            sr_load_en     <= 1'b0;
            sr_shift_en    <= 1'b0;
            sr_direction   <= 1'b0;
            sr_parallel_in <= '0;
        end else begin
            state          <= state_n;
            bit_cnt        <= bit_cnt_n;
            pace           <= pace_n;
            req_ready      <= req_ready_n;
            busy           <= busy_n;
            rsp_valid      <= rsp_valid_n;
            rsp_data       <= rsp_data_n;
            sr_load_en     <= load_n;
            sr_shift_en    <= shift_n;
            sr_direction   <= dir_n;
            sr_parallel_in <= pin_n;
        end
    end

    // pace counts down the idle cycles between pulses; the registered
    // sr_shift_en marks the cycle in which a pulse is actually issued.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        pace_n    = pace;
        shift_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = LOAD;
                    bit_cnt_n = eff_len;
                end
            end
            LOAD: begin
                state_n = SHIFT;
                shift_n = 1'b1;
                pace_n  = PACE_RELOAD;
            end
            SHIFT: begin
                if (sr_shift_en)
                    bit_cnt_n = bit_cnt - LEN_W'(1);
                if (sr_shift_en && bit_cnt == LEN_W'(1)) begin
                    state_n = CAPT;
                end else if (pace == '0) begin
                    shift_n = 1'b1;
                    pace_n  = PACE_RELOAD;
                end else begin
                    pace_n = pace - PACE_W'(1);
                end
            end
            CAPT: state_n = DONE;
            DONE: begin
                if (rsp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            shift_n = 1'b0;
        end
    end

    always_comb begin
        req_ready_n = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
        load_n      = (state_n == LOAD);
        rsp_valid_n = (state_n == DONE);
        dir_n       = accept ? req_lsb_first : sr_direction;
        pin_n       = accept ? req_data : sr_parallel_in;
        rsp_data_n  = (state == CAPT && state_n == DONE) ? sr_parallel_out : rsp_data;
    end

endmodule
